// File: rtl/lsu_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the load/store unit.
package lsu_pkg;
  typedef logic [3:0] op_t;

  localparam op_t OP_NOP = 4'd0;
  localparam op_t OP_LB  = 4'd1;
  localparam op_t OP_LH  = 4'd2;
  localparam op_t OP_LW  = 4'd3;
  localparam op_t OP_LD  = 4'd4;
  localparam op_t OP_LBU = 4'd5;
  localparam op_t OP_LHU = 4'd6;
  localparam op_t OP_LWU = 4'd7;
  localparam op_t OP_SB  = 4'd8;
  localparam op_t OP_SH  = 4'd9;
  localparam op_t OP_SW  = 4'd10;
  localparam op_t OP_SD  = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_store(input op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic is_load(input op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic is_unsigned(input op_t op);
    return op inside {OP_LBU, OP_LHU, OP_LWU};
  endfunction

  // log2 of the access size in bytes
  function automatic logic [1:0] size_of(input op_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_LWU, OP_SW: return 2'd2;
      OP_LD, OP_SD:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic is_legal(input op_t op, input int xlen);
    return (op <= OP_SD) && !((xlen == 32) && (op inside {OP_LD, OP_SD, OP_LWU}));
  endfunction
endpackage

// File: rtl/lsu_hs_if.sv
// Upstream, writeback and data-memory signals of lsu_hs; slave is the unit side.
interface lsu_hs_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  localparam int STRB_W = XLEN / 8;

  logic              i_valid;
  logic              o_ready;
  logic [3:0]        i_opt;
  logic [ADDR_W-1:0] i_addr;
  logic [XLEN-1:0]   i_regst;
  logic              o_valid;
  logic              i_ready;
  logic [XLEN-1:0]   o_regld;
  logic              o_err;
  logic              o_mem_req;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [XLEN-1:0]   o_mem_wdata;
  logic [STRB_W-1:0] o_mem_wstrb;
  logic              i_mem_ack;
  logic [XLEN-1:0]   i_mem_rdata;

  modport slave (
    input  i_valid, i_opt, i_addr, i_regst, i_ready, i_mem_ack, i_mem_rdata,
    output o_ready, o_valid, o_regld, o_err, o_mem_req, o_mem_we, o_mem_addr,
           o_mem_wdata, o_mem_wstrb
  );

  modport master (
    output i_valid, i_opt, i_addr, i_regst, i_ready, i_mem_ack, i_mem_rdata,
    input  o_ready, o_valid, o_regld, o_err, o_mem_req, o_mem_we, o_mem_addr,
           o_mem_wdata, o_mem_wstrb
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes/data placement, legality check, load extraction and extension.
module lsu_align import lsu_pkg::*; #(
  parameter  int XLEN   = 32,
  localparam int STRB_W = XLEN / 8,
  localparam int OFF_W  = $clog2(XLEN / 8)
) (
  input  logic [3:0]        i_op,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [XLEN-1:0]   i_regst,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [XLEN-1:0]   o_wdata,
  output logic              o_bad,
  output logic [XLEN-1:0]   o_ld
);
  logic [1:0]        w_size;
  logic [OFF_W-1:0]  w_mask;
  logic [STRB_W-1:0] w_strb_base;
  logic [XLEN-1:0]   w_sh;
  logic [XLEN-1:0]   w_keep;
  logic              w_sgn;

  always_comb begin
    w_size = size_of(i_op);
    w_mask = OFF_W'((4'd1 << w_size) - 4'd1);
    o_bad  = !is_legal(i_op, XLEN) || ((i_off & w_mask) != '0);

    case (w_size)
      2'd0:    w_strb_base = STRB_W'(1);
      2'd1:    w_strb_base = STRB_W'(3);
      2'd2:    w_strb_base = STRB_W'(15);
      default: w_strb_base = '1;
    endcase
    o_wstrb = is_store(i_op) ? (w_strb_base << i_off) : '0;
    o_wdata = is_store(i_op) ? (i_regst << {i_off, 3'b000}) : '0;

    // A shift of XLEN or more yields zero, so the keep mask saturates to all ones.
    w_sh   = i_rdata >> {i_off, 3'b000};
    w_keep = ~({XLEN{1'b1}} << (7'd8 << w_size));
    case (w_size)
      2'd0:    w_sgn = w_sh[7];
      2'd1:    w_sgn = w_sh[15];
      2'd2:    w_sgn = w_sh[31];
      default: w_sgn = w_sh[XLEN-1];
    endcase
    o_ld = '0;
    if (is_load(i_op))
      o_ld = (w_sh & w_keep) | ({XLEN{w_sgn & !is_unsigned(i_op)}} & ~w_keep);
  end
endmodule

// File: rtl/lsu_hs.sv
// Handshaked load/store unit; define LSU_TIMEOUT_EN to abort a request after TIMEOUT_CYC cycles without ack.
//   state   | meaning
//   IDLE    | ready for a new op
//   REQ     | memory request outstanding, waiting for ack
//   RESP    | result presented to writeback until accepted
module lsu_hs import lsu_pkg::*; #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic     i_clk,
  input logic     i_rst_n,
  lsu_hs_if.slave bus
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("lsu_hs: XLEN must be 32 or 64");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("lsu_hs: TIMEOUT_CYC must be at least 1");
  end

  logic [1:0]        r_state;
  logic [3:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [XLEN-1:0]   r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [XLEN-1:0]   r_regld;
  logic              r_err;

  logic              w_idle;
  logic              w_accept;
  logic              w_ack;
  logic              w_timeout;
  logic [3:0]        w_op;
  logic [OFF_W-1:0]  w_off;
  logic [STRB_W-1:0] w_wstrb;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_ld;
  logic              w_bad;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && bus.i_valid;
  assign w_ack    = (r_state == ST_REQ) && bus.i_mem_ack;

  // One align instance: decodes the incoming op in IDLE, the held op while in REQ.
  assign w_op  = w_idle ? bus.i_opt : r_op;
  assign w_off = w_idle ? bus.i_addr[OFF_W-1:0] : r_addr[OFF_W-1:0];

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_op    (w_op),
    .i_off   (w_off),
    .i_regst (bus.i_regst),
    .i_rdata (bus.i_mem_rdata),
    .o_wstrb (w_wstrb),
    .o_wdata (w_wdata),
    .o_bad   (w_bad),
    .o_ld    (w_ld)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= CNT_W'(TIMEOUT_CYC - 1);
    else if ((r_state == ST_REQ) && (r_cnt != '0))
      r_cnt <= r_cnt - 1'b1;
  end

  assign w_timeout = (r_state == ST_REQ) && !bus.i_mem_ack && (r_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_regld <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= bus.i_opt;
          r_addr  <= bus.i_addr;
          r_regld <= '0;
          r_err   <= w_bad;
          if (w_bad || (bus.i_opt == OP_NOP)) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_state <= ST_RESP;
          end else begin
            r_we    <= is_store(bus.i_opt);
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: if (w_ack) begin
          if (is_load(r_op)) r_regld <= w_ld;
          r_state <= ST_RESP;
        end else if (w_timeout) begin
          r_err   <= 1'b1;
          r_regld <= '0;
          r_state <= ST_RESP;
        end
        ST_RESP: if (bus.i_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready     = w_idle;
  assign bus.o_valid     = (r_state == ST_RESP);
  assign bus.o_mem_req   = (r_state == ST_REQ);
  assign bus.o_regld     = r_regld;
  assign bus.o_err       = r_err;
  assign bus.o_mem_we    = r_we;
  assign bus.o_mem_addr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.o_mem_wdata = r_wdata;
  assign bus.o_mem_wstrb = r_wstrb;
endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs: a 32-bit unit (TIMEOUT_CYC = 4) and a 64-bit unit side by side.
module tb_lsu_hs;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  lsu_hs_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  lsu_hs_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  lsu_hs #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b32)
  );
  lsu_hs #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] regst);
    @(negedge clk);
    b32.i_valid = 1'b1; b32.i_opt = op; b32.i_addr = addr; b32.i_regst = regst;
    @(negedge clk);
    b32.i_valid = 1'b0;
  endtask

  task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] regst, input logic [31:0] rdata, input bit mem,
                       input logic e_we, input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                       input logic [31:0] e_ld, input logic e_err);
    issue32(op, addr, regst);
    chk({tag, " req"}, 64'(b32.o_mem_req), 64'(mem));
    if (mem) begin
      chk({tag, " addr"},  64'(b32.o_mem_addr),  64'({addr[31:2], 2'b00}));
      chk({tag, " we"},    64'(b32.o_mem_we),    64'(e_we));
      chk({tag, " wdata"}, 64'(b32.o_mem_wdata), 64'(e_wdata));
      chk({tag, " wstrb"}, 64'(b32.o_mem_wstrb), 64'(e_wstrb));
      b32.i_mem_rdata = rdata; b32.i_mem_ack = 1'b1;
      @(negedge clk);
      b32.i_mem_ack = 1'b0;
    end
    chk({tag, " valid"}, 64'(b32.o_valid), 64'(1));
    chk({tag, " ready"}, 64'(b32.o_ready), 64'(0));
    chk({tag, " regld"}, 64'(b32.o_regld), 64'(e_ld));
    chk({tag, " err"},   64'(b32.o_err),   64'(e_err));
  endtask

  task automatic run64(input string tag, input logic [3:0] op, input logic [31:0] addr,
                       input logic [63:0] regst, input logic [63:0] rdata, input bit mem,
                       input logic e_we, input logic [63:0] e_wdata, input logic [7:0] e_wstrb,
                       input logic [63:0] e_ld, input logic e_err);
    @(negedge clk);
    b64.i_valid = 1'b1; b64.i_opt = op; b64.i_addr = addr; b64.i_regst = regst;
    @(negedge clk);
    b64.i_valid = 1'b0;
    chk({tag, " req"}, 64'(b64.o_mem_req), 64'(mem));
    if (mem) begin
      chk({tag, " addr"},  64'(b64.o_mem_addr),  64'({addr[31:3], 3'b000}));
      chk({tag, " we"},    64'(b64.o_mem_we),    64'(e_we));
      chk({tag, " wdata"}, b64.o_mem_wdata,      e_wdata);
      chk({tag, " wstrb"}, 64'(b64.o_mem_wstrb), 64'(e_wstrb));
      b64.i_mem_rdata = rdata; b64.i_mem_ack = 1'b1;
      @(negedge clk);
      b64.i_mem_ack = 1'b0;
    end
    chk({tag, " valid"}, 64'(b64.o_valid), 64'(1));
    chk({tag, " regld"}, b64.o_regld,      e_ld);
    chk({tag, " err"},   64'(b64.o_err),   64'(e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    b32.i_valid = 1'b0; b32.i_opt = OP_NOP; b32.i_addr = '0; b32.i_regst = '0;
    b32.i_ready = 1'b1; b32.i_mem_ack = 1'b0; b32.i_mem_rdata = '0;
    b64.i_valid = 1'b0; b64.i_opt = OP_NOP; b64.i_addr = '0; b64.i_regst = '0;
    b64.i_ready = 1'b1; b64.i_mem_ack = 1'b0; b64.i_mem_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst ready", 64'(b32.o_ready),     64'(1));
    chk("rst valid", 64'(b32.o_valid),     64'(0));
    chk("rst req",   64'(b32.o_mem_req),   64'(0));
    chk("rst err",   64'(b32.o_err),       64'(0));
    chk("rst regld", 64'(b32.o_regld),     64'(0));
    chk("rst addr",  64'(b32.o_mem_addr),  64'(0));
    chk("rst we",    64'(b32.o_mem_we),    64'(0));
    chk("rst wdata", 64'(b32.o_mem_wdata), 64'(0));
    chk("rst wstrb", 64'(b32.o_mem_wstrb), 64'(0));
    chk("rst64 ready", 64'(b64.o_ready),   64'(1));
    rst_n = 1'b1;

    // LB at 0x1003: ack on the second REQ cycle, o_valid on cycle 4, then stall writeback
    issue32(OP_LB, 32'h1003, 32'h0);
    chk("lb c2 valid", 64'(b32.o_valid),     64'(0));
    chk("lb c2 req",   64'(b32.o_mem_req),   64'(1));
    chk("lb addr",     64'(b32.o_mem_addr),  64'(32'h1000));
    chk("lb we",       64'(b32.o_mem_we),    64'(0));
    chk("lb wstrb",    64'(b32.o_mem_wstrb), 64'(0));
    @(negedge clk);
    chk("lb c3 valid", 64'(b32.o_valid),     64'(0));
    b32.i_mem_rdata = 32'h80FF_FF00; b32.i_mem_ack = 1'b1; b32.i_ready = 1'b0;
    @(negedge clk);
    b32.i_mem_ack = 1'b0;
    chk("lb c4 valid", 64'(b32.o_valid),     64'(1));
    chk("lb regld",    64'(b32.o_regld),     64'(32'hFFFF_FF80));
    chk("lb err",      64'(b32.o_err),       64'(0));
    chk("lb req off",  64'(b32.o_mem_req),   64'(0));
    b32.i_mem_rdata = 32'h0; b32.i_mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b32.i_mem_ack = 1'b0;
      chk("stall valid", 64'(b32.o_valid), 64'(1));
      chk("stall regld", 64'(b32.o_regld), 64'(32'hFFFF_FF80));
      chk("stall err",   64'(b32.o_err),   64'(0));
      chk("stall ready", 64'(b32.o_ready), 64'(0));
    end
    b32.i_ready = 1'b1;
    @(negedge clk);
    chk("release valid", 64'(b32.o_valid), 64'(0));
    chk("release ready", 64'(b32.o_ready), 64'(1));

    //     tag       op      addr        regst          rdata          mem we wdata          wstrb  regld          err
    run32("lw",     OP_LW,  32'h5004, 32'h0,         32'hCAFE_BABE, 1, 0, 32'h0,         4'h0, 32'hCAFE_BABE, 0);
    run32("sh",     OP_SH,  32'h2002, 32'h0000_ABCD, 32'h0,         1, 1, 32'hABCD_0000, 4'hC, 32'h0,         0);
    run32("sb",     OP_SB,  32'h4001, 32'h0000_0055, 32'h0,         1, 1, 32'h0000_5500, 4'h2, 32'h0,         0);
    run32("sw",     OP_SW,  32'h5000, 32'h1234_5678, 32'h0,         1, 1, 32'h1234_5678, 4'hF, 32'h0,         0);
    run32("lh",     OP_LH,  32'h3002, 32'h0,         32'h8001_1234, 1, 0, 32'h0,         4'h0, 32'hFFFF_8001, 0);
    run32("lhu",    OP_LHU, 32'h3002, 32'h0,         32'h8001_1234, 1, 0, 32'h0,         4'h0, 32'h0000_8001, 0);
    run32("lbu",    OP_LBU, 32'h3001, 32'h0,         32'h0000_9A00, 1, 0, 32'h0,         4'h0, 32'h0000_009A, 0);
    run32("lb pos", OP_LB,  32'h1002, 32'h0,         32'h0012_7F00, 1, 0, 32'h0,         4'h0, 32'h0000_0012, 0);
    run32("lw mis", OP_LW,  32'h1001, 32'h0,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         1);
    run32("sh mis", OP_SH,  32'h2001, 32'h1,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         1);
    run32("lh mis", OP_LH,  32'h3003, 32'h0,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         1);
    run32("lwu32",  OP_LWU, 32'h8004, 32'h0,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         1);
    run32("ld32",   OP_LD,  32'h8000, 32'h0,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         1);
    run32("sd32",   OP_SD,  32'h8000, 32'h0,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         1);
    run32("undef",  4'd13,  32'h0000, 32'h0,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         1);
    run32("nop",    OP_NOP, 32'h0000, 32'h0,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         0);

    run64("lwu64",  OP_LWU, 32'h8004, 64'h0, 64'hDEAD_BEEF_0000_0000, 1, 0, 64'h0, 8'h00, 64'h0000_0000_DEAD_BEEF, 0);
    run64("lw64",   OP_LW,  32'h8004, 64'h0, 64'h8000_0000_1111_2222, 1, 0, 64'h0, 8'h00, 64'hFFFF_FFFF_8000_0000, 0);
    run64("ld64",   OP_LD,  32'h8008, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 0);
    run64("sd64",   OP_SD,  32'h8010, 64'h1122_3344_5566_7788, 64'h0, 1, 1, 64'h1122_3344_5566_7788, 8'hFF, 64'h0, 0);
    run64("sw64",   OP_SW,  32'h8014, 64'h0000_0000_AABB_CCDD, 64'h0, 1, 1, 64'hAABB_CCDD_0000_0000, 8'hF0, 64'h0, 0);
    run64("ld mis", OP_LD,  32'h8004, 64'h0, 64'h0, 0, 0, 64'h0, 8'h00, 64'h0, 1);

    // Reset while a request is outstanding, then a late ack
    issue32(OP_LW, 32'h7000, 32'h0);
    chk("mid req", 64'(b32.o_mem_req), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async req",   64'(b32.o_mem_req), 64'(0));
    chk("async ready", 64'(b32.o_ready),   64'(1));
    chk("async valid", 64'(b32.o_valid),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    b32.i_mem_rdata = 32'h1234_5678; b32.i_mem_ack = 1'b1;
    @(negedge clk);
    b32.i_mem_ack = 1'b0;
    chk("late ack valid", 64'(b32.o_valid),   64'(0));
    chk("late ack req",   64'(b32.o_mem_req), 64'(0));
    chk("late ack ready", 64'(b32.o_ready),   64'(1));

`ifdef LSU_TIMEOUT_EN
    issue32(OP_LW, 32'h6000, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("to req held", 64'(b32.o_mem_req), 64'(1));
      @(negedge clk);
    end
    chk("to req drop", 64'(b32.o_mem_req), 64'(0));
    chk("to valid",    64'(b32.o_valid),   64'(1));
    chk("to err",      64'(b32.o_err),     64'(1));
    chk("to regld",    64'(b32.o_regld),   64'(0));
    issue32(OP_LW, 32'h6004, 32'h0);
    repeat (3) @(negedge clk);
    chk("to4 req", 64'(b32.o_mem_req), 64'(1));
    b32.i_mem_rdata = 32'h0BAD_F00D; b32.i_mem_ack = 1'b1;
    @(negedge clk);
    b32.i_mem_ack = 1'b0;
    chk("to4 valid", 64'(b32.o_valid), 64'(1));
    chk("to4 err",   64'(b32.o_err),   64'(0));
    chk("to4 regld", 64'(b32.o_regld), 64'(32'h0BAD_F00D));
`else
    issue32(OP_LW, 32'h6000, 32'h0);
    repeat (12) @(negedge clk);
    chk("wait req",   64'(b32.o_mem_req), 64'(1));
    chk("wait valid", 64'(b32.o_valid),   64'(0));
    b32.i_mem_rdata = 32'h0BAD_F00D; b32.i_mem_ack = 1'b1;
    @(negedge clk);
    b32.i_mem_ack = 1'b0;
    chk("wait ack valid", 64'(b32.o_valid), 64'(1));
    chk("wait ack err",   64'(b32.o_err),   64'(0));
    chk("wait ack regld", 64'(b32.o_regld), 64'(32'h0BAD_F00D));
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
